// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_types_pkg : shared types for the vector register file          |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
package cpu_types_pkg;

   localparam int VRF_NREGS   = 32;
   localparam int VRF_THREADS = 4;
   localparam int VRF_WORD_W  = 32;

   typedef logic [VRF_WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } vrf_state_t;

endpackage
`default_nettype wire

// File: rtl/vrf_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vrf_scoreboard : per-register busy bits gating instruction issue   |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
module vrf_scoreboard
   import cpu_types_pkg::*;
#(
   parameter int NREGS = VRF_NREGS,
   parameter int SEL_W = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic             idle_i,
   input  logic             bulk_clr_i,
   input  logic             iss_valid_i,
   input  logic [SEL_W-1:0] iss_dst_i,
   input  logic [SEL_W-1:0] iss_rs1_i,
   input  logic [SEL_W-1:0] iss_rs2_i,
   input  logic             wlast_a_i,
   input  logic [SEL_W-1:0] wsel_a_i,
   input  logic             wlast_m_i,
   input  logic [SEL_W-1:0] wsel_m_i,
   output logic             iss_ready_o
);

   logic [NREGS-1:0] busy_q, busy_d;
   logic             iss_fire;

   assign iss_ready_o = idle_i && !busy_q[iss_dst_i] && !busy_q[iss_rs1_i] && !busy_q[iss_rs2_i];
   assign iss_fire    = iss_valid_i && iss_ready_o;

   // Order encodes priority: set beats writeback clear, bulk clear beats all.
   always_comb begin
      busy_d = busy_q;
      if (wlast_a_i) busy_d[wsel_a_i] = 1'b0;
      if (wlast_m_i) busy_d[wsel_m_i] = 1'b0;
      if (iss_fire)  busy_d[iss_dst_i] = 1'b1;
      if (bulk_clr_i) busy_d = '0;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge nRST) begin
      if (nRST) busy_q <= '0;
      else      busy_q <= busy_d;
   end

endmodule
`default_nettype wire

// File: rtl/vector_register_file_sb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vector_register_file_sb : per-lane VRF, bypassed reads, scoreboard |
// | Revision                : 1.0                                      |
// +--------------------------------------------------------------------+
module vector_register_file_sb
   import cpu_types_pkg::*;
#(
   parameter int THREADS = VRF_THREADS,
   parameter int NREGS   = VRF_NREGS,
   parameter int WORD_W  = VRF_WORD_W
) (
   input  logic                        clk,
   input  logic                        nRST,
   input  logic [$clog2(NREGS)-1:0]    rsel1,
   input  logic [$clog2(NREGS)-1:0]    rsel2,
   output logic [THREADS*WORD_W-1:0]   rdata1,
   output logic [THREADS*WORD_W-1:0]   rdata2,
   input  logic [$clog2(NREGS)-1:0]    wsel_a,
   input  logic [THREADS-1:0]          wen_a,
   input  logic [THREADS*WORD_W-1:0]   wdata_a,
   input  logic [$clog2(NREGS)-1:0]    wsel_m,
   input  logic [THREADS-1:0]          wen_m,
   input  logic [THREADS*WORD_W-1:0]   wdata_m,
   input  logic                        wlast_a,
   input  logic                        wlast_m,
   input  logic                        iss_valid,
   input  logic [$clog2(NREGS)-1:0]    iss_dst,
   input  logic [$clog2(NREGS)-1:0]    iss_rs1,
   input  logic [$clog2(NREGS)-1:0]    iss_rs2,
   output logic                        iss_ready,
   input  logic                        clr_req,
   output logic                        clr_busy
);

   localparam int SEL_W = $clog2(NREGS);
   localparam int VEC_W = THREADS * WORD_W;

   vrf_state_t         state_q, state_d;
   logic [SEL_W-1:0]   idx_q, idx_d;
   logic [VEC_W-1:0]   regs_q [NREGS];
   logic               idle;
   logic [THREADS-1:0] wen_a_eff, wen_m_eff;

   assign idle     = (state_q == IDLE);
   assign clr_busy = !idle;

   // Writes are dropped while clearing and to the hardwired zero register.
   assign wen_a_eff = (idle && wsel_a != '0) ? wen_a : '0;
   assign wen_m_eff = (idle && wsel_m != '0) ? wen_m : '0;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               idx_d   = SEL_W'(1);
            end
         end
         CLEAR: begin
            if (idx_q == SEL_W'(NREGS - 1)) state_d = DONE;
            else                            idx_d   = idx_q + 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge nRST) begin
      if (nRST) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // MEM assignment comes last so it wins a same-lane collision.
   always_ff @(posedge clk or posedge nRST) begin
      if (nRST) begin
         for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      end else if (state_q == CLEAR) begin
         regs_q[idx_q] <= '0;
      end else begin
         for (int i = 0; i < THREADS; i++) begin
            if (wen_a_eff[i]) regs_q[wsel_a][i*WORD_W +: WORD_W] <= wdata_a[i*WORD_W +: WORD_W];
            if (wen_m_eff[i]) regs_q[wsel_m][i*WORD_W +: WORD_W] <= wdata_m[i*WORD_W +: WORD_W];
         end
      end
   end

   always_comb begin
      rdata1 = regs_q[rsel1];
      rdata2 = regs_q[rsel2];
      for (int i = 0; i < THREADS; i++) begin
         if (wen_a_eff[i] && wsel_a == rsel1) rdata1[i*WORD_W +: WORD_W] = wdata_a[i*WORD_W +: WORD_W];
         if (wen_m_eff[i] && wsel_m == rsel1) rdata1[i*WORD_W +: WORD_W] = wdata_m[i*WORD_W +: WORD_W];
         if (wen_a_eff[i] && wsel_a == rsel2) rdata2[i*WORD_W +: WORD_W] = wdata_a[i*WORD_W +: WORD_W];
         if (wen_m_eff[i] && wsel_m == rsel2) rdata2[i*WORD_W +: WORD_W] = wdata_m[i*WORD_W +: WORD_W];
      end
      if (rsel1 == '0) rdata1 = '0;
      if (rsel2 == '0) rdata2 = '0;
   end

   vrf_scoreboard #(
      .NREGS (NREGS),
      .SEL_W (SEL_W)
   ) u_scoreboard (
      .clk         (clk),
      .nRST        (nRST),
      .idle_i      (idle),
      .bulk_clr_i  (!idle),
      .iss_valid_i (iss_valid),
      .iss_dst_i   (iss_dst),
      .iss_rs1_i   (iss_rs1),
      .iss_rs2_i   (iss_rs2),
      .wlast_a_i   (wlast_a),
      .wsel_a_i    (wsel_a),
      .wlast_m_i   (wlast_m),
      .wsel_m_i    (wsel_m),
      .iss_ready_o (iss_ready)
   );

endmodule
`default_nettype wire

// File: tb/tb_vector_register_file_sb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vector_register_file_sb : directed self-checking bench          |
// | Revision                   : 1.0                                   |
// +--------------------------------------------------------------------+
module tb_vector_register_file_sb;

   localparam int THREADS = 4;
   localparam int NREGS   = 32;
   localparam int WORD_W  = 32;
   localparam int SEL_W   = 5;
   localparam int VEC_W   = THREADS * WORD_W;

   logic               clk = 1'b0;
   logic               nRST;
   logic [SEL_W-1:0]   rsel1, rsel2, wsel_a, wsel_m, iss_dst, iss_rs1, iss_rs2;
   logic [VEC_W-1:0]   rdata1, rdata2, wdata_a, wdata_m;
   logic [THREADS-1:0] wen_a, wen_m;
   logic               wlast_a, wlast_m, iss_valid, iss_ready, clr_req, clr_busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   vector_register_file_sb #(
      .THREADS (THREADS),
      .NREGS   (NREGS),
      .WORD_W  (WORD_W)
   ) dut (
      .clk       (clk),
      .nRST      (nRST),
      .rsel1     (rsel1),
      .rsel2     (rsel2),
      .rdata1    (rdata1),
      .rdata2    (rdata2),
      .wsel_a    (wsel_a),
      .wen_a     (wen_a),
      .wdata_a   (wdata_a),
      .wsel_m    (wsel_m),
      .wen_m     (wen_m),
      .wdata_m   (wdata_m),
      .wlast_a   (wlast_a),
      .wlast_m   (wlast_m),
      .iss_valid (iss_valid),
      .iss_dst   (iss_dst),
      .iss_rs1   (iss_rs1),
      .iss_rs2   (iss_rs2),
      .iss_ready (iss_ready),
      .clr_req   (clr_req),
      .clr_busy  (clr_busy)
   );

   task automatic check(input string tag, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are read 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [VEC_W-1:0] fill_vec(input int r);
      logic [VEC_W-1:0] v;
      for (int i = 0; i < THREADS; i++) v[i*WORD_W +: WORD_W] = 32'h100 * r + i + 1;
      return v;
   endfunction

   function automatic logic [VEC_W-1:0] vec4(input logic [31:0] l3, input logic [31:0] l2,
                                             input logic [31:0] l1, input logic [31:0] l0);
      return {l3, l2, l1, l0};
   endfunction

   task automatic idle_ports();
      wen_a = '0; wen_m = '0; wlast_a = 1'b0; wlast_m = 1'b0;
      iss_valid = 1'b0; clr_req = 1'b0;
      wsel_a = '0; wsel_m = '0; iss_dst = '0; iss_rs1 = '0; iss_rs2 = '0;
   endtask

   task automatic fill_all();
      for (int r = 1; r < NREGS; r++) begin
         wsel_a = SEL_W'(r); wen_a = '1; wdata_a = fill_vec(r);
         tick();
      end
      wen_a = '0;
   endtask

   int  cnt;
   logic ready_seen;

   initial begin
      nRST = 1'b1;
      rsel1 = '0; rsel2 = '0; wdata_a = '0; wdata_m = '0;
      idle_ports();
      tick(); tick();
      nRST = 1'b0;
      #1;

      // 1: reset state
      rsel1 = 5'd5;
      #1;
      check("reset_rdata1", rdata1, '0);
      check("reset_ready", {127'b0, iss_ready}, 128'd1);
      check("reset_clr_busy", {127'b0, clr_busy}, 128'd0);

      // 2: masked ALU write with same-cycle bypass
      wsel_a = 5'd3; wen_a = 4'b1111; wdata_a = fill_vec(3);
      tick();
      wen_a = 4'b0101; wdata_a = vec4(32'hAA, 32'hAA, 32'hAA, 32'hAA);
      rsel1 = 5'd3;
      #1;
      check("bypass_masked", rdata1, vec4(32'h304, 32'hAA, 32'h302, 32'hAA));
      tick();
      wen_a = '0;
      #1;
      check("stored_masked", rdata1, vec4(32'h304, 32'hAA, 32'h302, 32'hAA));

      // 3: ALU/MEM collision on reg 7 lane 1, then disjoint lanes on reg 8
      wsel_a = 5'd7; wen_a = 4'b0010; wdata_a = vec4(0, 0, 32'h11, 0);
      wsel_m = 5'd7; wen_m = 4'b0010; wdata_m = vec4(0, 0, 32'h22, 0);
      rsel2 = 5'd7;
      #1;
      check("collide_bypass", rdata2, vec4(0, 0, 32'h22, 0));
      tick();
      wen_a = '0; wen_m = '0;
      #1;
      check("collide_stored", rdata2, vec4(0, 0, 32'h22, 0));
      wsel_a = 5'd8; wen_a = 4'b0001; wdata_a = vec4(0, 0, 0, 32'h33);
      wsel_m = 5'd8; wen_m = 4'b0100; wdata_m = vec4(0, 32'h44, 0, 0);
      tick();
      wen_a = '0; wen_m = '0; rsel2 = 5'd8;
      #1;
      check("disjoint_lanes", rdata2, vec4(0, 32'h44, 0, 32'h33));

      // 4: scoreboard set on issue, clear on wlast with no lane enabled
      iss_valid = 1'b1; iss_dst = 5'd4; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
      #1;
      check("issue_ready", {127'b0, iss_ready}, 128'd1);
      tick();
      iss_dst = 5'd5; iss_rs1 = 5'd4;
      #1;
      check("raw_stall", {127'b0, iss_ready}, 128'd0);
      iss_valid = 1'b0;
      wlast_m = 1'b1; wsel_m = 5'd4;
      tick();
      wlast_m = 1'b0;
      #1;
      check("wlast_release", {127'b0, iss_ready}, 128'd1);

      // set and clear of reg 6 in the same cycle: set wins
      iss_valid = 1'b1; iss_dst = 5'd6; iss_rs1 = 5'd0;
      wlast_a = 1'b1; wsel_a = 5'd6;
      tick();
      iss_valid = 1'b0; wlast_a = 1'b0; iss_dst = 5'd0; iss_rs1 = 5'd6;
      #1;
      check("set_beats_clear", {127'b0, iss_ready}, 128'd0);
      wlast_a = 1'b1; wsel_a = 5'd6;
      tick();
      wlast_a = 1'b0;

      // 5: register 0 is hardwired zero and never busy
      wsel_a = 5'd0; wen_a = '1; wdata_a = '1;
      wsel_m = 5'd0; wen_m = '1; wdata_m = '1;
      rsel1 = 5'd0; iss_rs1 = 5'd0; iss_dst = 5'd0; iss_valid = 1'b1;
      #1;
      check("r0_bypass", rdata1, '0);
      tick();
      wen_a = '0; wen_m = '0;
      #1;
      check("r0_stored", rdata1, '0);
      check("r0_not_busy", {127'b0, iss_ready}, 128'd1);
      iss_valid = 1'b0;

      // 6: full clear sequence, with a busy reg and writes attempted mid-clear
      fill_all();
      iss_valid = 1'b1; iss_dst = 5'd9;
      tick();
      iss_valid = 1'b0; iss_dst = 5'd0;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      cnt = 0; ready_seen = 1'b0;
      while (clr_busy && cnt < 100) begin
         cnt++;
         if (iss_ready) ready_seen = 1'b1;
         if (cnt == 3) begin
            rsel1 = 5'd2; rsel2 = 5'd3;
            wsel_a = 5'd2; wen_a = '1; wdata_a = '1;
            #1;
            check("mid_clear_r2", rdata1, '0);
            check("mid_clear_r3", rdata2, fill_vec(3));
         end
         tick();
         wen_a = '0;
      end
      check("clear_cycles", 128'(cnt), 128'd32);
      check("clear_no_ready", {127'b0, ready_seen}, 128'd0);
      for (int r = 1; r < NREGS; r++) begin
         rsel1 = SEL_W'(r);
         #1;
         check($sformatf("cleared_r%0d", r), rdata1, '0);
      end
      iss_rs1 = 5'd9;
      #1;
      check("busy_cleared", {127'b0, iss_ready}, 128'd1);
      iss_rs1 = 5'd0;

      // reset in the middle of a clear
      fill_all();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      #2;
      nRST = 1'b1;
      #1;
      check("rst_mid_clr_busy", {127'b0, clr_busy}, 128'd0);
      tick();
      nRST = 1'b0;
      tick();
      check("rst_no_resume", {127'b0, clr_busy}, 128'd0);
      check("rst_ready", {127'b0, iss_ready}, 128'd1);
      for (int r = 1; r < NREGS; r += 10) begin
         rsel2 = SEL_W'(r);
         #1;
         check($sformatf("rst_zero_r%0d", r), rdata2, '0);
      end
      rsel2 = 5'd31;
      #1;
      check("rst_zero_r31", rdata2, '0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
